// File: rtl/ram_unit_be.sv
// Dual-port RAM (data + instruction port) with per-lane byte enables,
// optional registered read and a hardware clear sequencer that zeroes the array.
module ram_unit_be #(
    parameter int A      = 8,
    parameter int D      = 8,
    parameter int LANE   = 8,
    parameter int RD_REG = 0,
    parameter int PRIO   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    output logic                 busy,
    input  logic [A-1:0]         address,
    input  logic [D-1:0]         dbusi,
    output logic [D-1:0]         dbuso,
    input  logic                 ce,
    input  logic                 we,
    input  logic [D/LANE-1:0]    be,
    input  logic [A-1:0]         iaddress,
    input  logic [D-1:0]         idbusi,
    output logic [D-1:0]         idbuso,
    input  logic                 ice,
    input  logic                 iwe,
    input  logic [D/LANE-1:0]    ibe
);

    localparam int NL    = D / LANE;
    localparam int DEPTH = 2 ** A;
    localparam bit IPRIO = (PRIO != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [A-1:0]   r_clrPtr;
    logic [A-1:0]   w_nextPtr;
    logic           w_busy;
    logic           w_sameAddr;
    logic           w_dWr;
    logic           w_iWr;
    logic [NL-1:0]  w_dLane;
    logic [NL-1:0]  w_iLane;
    logic [D-1:0]   r_mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CLEAR;
            r_clrPtr <= '0;
        end else begin
            r_state  <= w_nextState;
            r_clrPtr <= w_nextPtr;
        end
    end

    // Clear walks every address once; a clear request is only honoured from IDLE.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_clrPtr;
        case (r_state)
            CLEAR: begin
                w_nextPtr = r_clrPtr + A'(1);
                if (r_clrPtr == {A{1'b1}}) begin
                    w_nextState = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    w_nextState = CLEAR;
                    w_nextPtr   = '0;
                end
            end
            default: begin
                w_nextState = CLEAR;
                w_nextPtr   = '0;
            end
        endcase
    end

    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;

    // Per-lane collision resolution: a lane both ports enable goes to the PRIO winner only.
    always_comb begin
        w_sameAddr = (address == iaddress);
        w_dWr      = ce & we;
        w_iWr      = ice & iwe;
        w_dLane    = '0;
        w_iLane    = '0;
        for (int k = 0; k < NL; k++) begin
            w_dLane[k] = w_dWr & be[k]  & ~(w_sameAddr & w_iWr & ibe[k] & IPRIO);
            w_iLane[k] = w_iWr & ibe[k] & ~(w_sameAddr & w_dWr & be[k]  & ~IPRIO);
        end
    end

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clrPtr] <= '0;
        end else if (!clear) begin
            for (int k = 0; k < NL; k++) begin
                if (w_dLane[k]) begin
                    r_mem[address][k*LANE +: LANE] <= dbusi[k*LANE +: LANE];
                end
                if (w_iLane[k]) begin
                    r_mem[iaddress][k*LANE +: LANE] <= idbusi[k*LANE +: LANE];
                end
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_regRead
            logic [D-1:0] r_dbuso;
            logic [D-1:0] r_idbuso;

            // Registered reads sample the array before this edge's writes land.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dbuso  <= '0;
                    r_idbuso <= '0;
                end else if (w_busy) begin
                    r_dbuso  <= '0;
                    r_idbuso <= '0;
                end else begin
                    if (ce) begin
                        r_dbuso <= r_mem[address];
                    end
                    if (ice) begin
                        r_idbuso <= r_mem[iaddress];
                    end
                end
            end

            assign dbuso  = r_dbuso;
            assign idbuso = r_idbuso;
        end else begin : g_combRead
            assign dbuso  = w_busy ? '0 : r_mem[address];
            assign idbuso = w_busy ? '0 : r_mem[iaddress];
        end
    endgenerate

endmodule

// File: tb/tb_ram_unit_be.sv
// Directed bench for ram_unit_be: two instances (PRIO=0 and PRIO=1) share stimulus
// and are compared every cycle against a word-level model of the memory.
module tb_ram_unit_be;

    localparam int A = 4;
    localparam int D = 16;
    localparam int LANE = 8;
    localparam int NL = D / LANE;
    localparam int DEPTH = 2 ** A;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic ce = 1'b0;
    logic we = 1'b0;
    logic [NL-1:0] be = '0;
    logic [A-1:0] address = '0;
    logic [D-1:0] dbusi = '0;
    logic ice = 1'b0;
    logic iwe = 1'b0;
    logic [NL-1:0] ibe = '0;
    logic [A-1:0] iaddress = '0;
    logic [D-1:0] idbusi = '0;

    logic busy0, busy1;
    logic [D-1:0] dbuso0, dbuso1, idbuso0, idbuso1;

    int nChecks = 0;
    int nFails = 0;
    bit checkEn = 1'b0;

    ram_unit_be #(.A(A), .D(D), .LANE(LANE), .RD_REG(1), .PRIO(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy0),
        .address(address), .dbusi(dbusi), .dbuso(dbuso0), .ce(ce), .we(we), .be(be),
        .iaddress(iaddress), .idbusi(idbusi), .idbuso(idbuso0), .ice(ice), .iwe(iwe), .ibe(ibe)
    );

    ram_unit_be #(.A(A), .D(D), .LANE(LANE), .RD_REG(1), .PRIO(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1),
        .address(address), .dbusi(dbusi), .dbuso(dbuso1), .ce(ce), .we(we), .be(be),
        .iaddress(iaddress), .idbusi(idbusi), .idbuso(idbuso1), .ice(ice), .iwe(iwe), .ibe(ibe)
    );

    always #5 clk = ~clk;

    // Model state: one memory image per PRIO setting, busy as a countdown of clear edges.
    logic [D-1:0] mMem0 [DEPTH];
    logic [D-1:0] mMem1 [DEPTH];
    logic [D-1:0] expD0 = '0, expI0 = '0, expD1 = '0, expI1 = '0;
    int busyLeft = DEPTH;

    function automatic logic [D-1:0] mergeLanes(input logic [D-1:0] old, input logic [D-1:0] data,
                                                input logic [NL-1:0] en);
        logic [D-1:0] w;
        w = old;
        for (int k = 0; k < NL; k++) begin
            if (en[k]) w[k*LANE +: LANE] = data[k*LANE +: LANE];
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyLeft = DEPTH;
            expD0 = '0; expI0 = '0; expD1 = '0; expI1 = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mMem0[i] = '0;
                mMem1[i] = '0;
            end
        end else if (busyLeft > 0) begin
            expD0 = '0; expI0 = '0; expD1 = '0; expI1 = '0;
            busyLeft = busyLeft - 1;
        end else begin
            if (ce) begin
                expD0 = mMem0[address];
                expD1 = mMem1[address];
            end
            if (ice) begin
                expI0 = mMem0[iaddress];
                expI1 = mMem1[iaddress];
            end
            if (clear) begin
                busyLeft = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    mMem0[i] = '0;
                    mMem1[i] = '0;
                end
            end else begin
                // Loser applied first, winner overwrites its enabled lanes.
                if (ice && iwe) mMem0[iaddress] = mergeLanes(mMem0[iaddress], idbusi, ibe);
                if (ce && we)   mMem0[address]  = mergeLanes(mMem0[address], dbusi, be);
                if (ce && we)   mMem1[address]  = mergeLanes(mMem1[address], dbusi, be);
                if (ice && iwe) mMem1[iaddress] = mergeLanes(mMem1[iaddress], idbusi, ibe);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy0", 32'(busy0), 32'(busyLeft > 0));
            checkOutput("busy1", 32'(busy1), 32'(busyLeft > 0));
            checkOutput("dbuso0", 32'(dbuso0), 32'(expD0));
            checkOutput("dbuso1", 32'(dbuso1), 32'(expD1));
            checkOutput("idbuso0", 32'(idbuso0), 32'(expI0));
            checkOutput("idbuso1", 32'(idbuso1), 32'(expI1));
        end
    end

    task automatic setInputs(input logic iClear, input logic iCe, input logic iWe, input logic [NL-1:0] iBe,
                             input logic [A-1:0] iAddr, input logic [D-1:0] iData,
                             input logic iIce, input logic iIwe, input logic [NL-1:0] iIbe,
                             input logic [A-1:0] iIaddr, input logic [D-1:0] iIdata);
        clear = iClear;
        ce = iCe; we = iWe; be = iBe; address = iAddr; dbusi = iData;
        ice = iIce; iwe = iIwe; ibe = iIbe; iaddress = iIaddr; idbusi = iIdata;
    endtask

    task automatic applyStimulus(input logic iClear, input logic iCe, input logic iWe, input logic [NL-1:0] iBe,
                                 input logic [A-1:0] iAddr, input logic [D-1:0] iData,
                                 input logic iIce, input logic iIwe, input logic [NL-1:0] iIbe,
                                 input logic [A-1:0] iIaddr, input logic [D-1:0] iIdata);
        setInputs(iClear, iCe, iWe, iBe, iAddr, iData, iIce, iIwe, iIbe, iIaddr, iIdata);
        @(negedge clk);
    endtask

    task automatic readBoth(input logic [A-1:0] dAddr, input logic [A-1:0] iAddr);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, dAddr, '0, 1'b1, 1'b0, '0, iAddr, '0);
    endtask

    task automatic waitIdle(input string name);
        int cnt;
        cnt = 0;
        setInputs(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            cnt = n;
            if (busy0 === 1'b0) break;
        end
        checkOutput(name, 32'(cnt), 32'd16);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 checkEn = 1'b1;
        #2;
        checkOutput("resetBusy", 32'(busy0), 32'd1);
        checkOutput("resetDbuso", 32'(dbuso0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitIdle("resetBusyEdges");

        for (int i = 0; i < DEPTH; i++) begin
            readBoth(A'(i), A'(DEPTH - 1 - i));
            checkOutput("initSweepD", 32'(dbuso0), 32'd0);
            checkOutput("initSweepI", 32'(idbuso1), 32'd0);
        end

        // Read-first on the write edge, new data one edge later.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd3, 16'hABCD, 1'b1, 1'b0, '0, 4'd3, '0);
        checkOutput("sameEdgeRead", 32'(idbuso0), 32'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 4'd3, '0);
        checkOutput("readAfterWrite", 32'(idbuso0), 32'hABCD);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 4'd5, 16'hFFEE, 1'b0, 1'b0, '0, '0, '0);
        readBoth(4'd5, 4'd5);
        checkOutput("laneLow", 32'(dbuso0), 32'h12EE);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 4'd5, 16'h77AA, 1'b0, 1'b0, '0, '0, '0);
        readBoth(4'd5, 4'd5);
        checkOutput("laneHigh", 32'(dbuso1), 32'h77EE);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 4'd5, 16'h0000, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("noLaneReadStill", 32'(dbuso0), 32'h77EE);
        readBoth(4'd5, 4'd5);
        checkOutput("noLaneUnchanged", 32'(idbuso0), 32'h77EE);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd7, 16'hAAAA, 1'b1, 1'b1, 2'b01, 4'd7, 16'h5555);
        readBoth(4'd7, 4'd7);
        checkOutput("collidePrio0", 32'(dbuso0), 32'hAAAA);
        checkOutput("collidePrio1", 32'(dbuso1), 32'hAA55);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 4'd8, 16'h1111, 1'b1, 1'b1, 2'b11, 4'd8, 16'h2222);
        readBoth(4'd8, 4'd8);
        checkOutput("collide2Prio0", 32'(idbuso0), 32'h2211);
        checkOutput("collide2Prio1", 32'(idbuso1), 32'h2222);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd9, 16'h0909, 1'b1, 1'b1, 2'b11, 4'd10, 16'h1010);
        readBoth(4'd9, 4'd10);
        checkOutput("splitWriteD", 32'(dbuso1), 32'h0909);
        checkOutput("splitWriteI", 32'(idbuso0), 32'h1010);

        // Reset in the middle of normal access.
        readBoth(4'd7, 4'd7);
        checkOutput("preResetRead", 32'(dbuso1), 32'hAA55);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midAccessResetD", 32'(dbuso0), 32'h0000);
        checkOutput("midAccessResetI", 32'(idbuso1), 32'h0000);
        checkOutput("midAccessResetBusy", 32'(busy0), 32'd1);
        setInputs(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        waitIdle("accessResetBusyEdges");

        // Clear request with a colliding write and a second clear mid-sequence.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd2, 16'h2222, 1'b1, 1'b1, 2'b11, 4'd4, 16'h4444);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 4'd2, 16'h9999, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("clearReadFirst", 32'(dbuso0), 32'h2222);
        checkOutput("clearBusy", 32'(busy1), 32'd1);
        begin
            int cnt;
            cnt = 0;
            for (int n = 1; n <= 40; n++) begin
                applyStimulus(n == 5, 1'b1, 1'b1, 2'b11, A'(n), 16'hBEEF, 1'b1, 1'b1, 2'b11, A'(n + 3), 16'hCAFE);
                cnt = n;
                if (n == 3) checkOutput("midClearRead", 32'(dbuso0), 32'h0000);
                if (busy0 === 1'b0) break;
            end
            checkOutput("clearBusyEdges", 32'(cnt), 32'd16);
        end
        for (int i = 0; i < DEPTH; i++) begin
            readBoth(A'(i), A'(DEPTH - 1 - i));
            checkOutput("postClearD", 32'(dbuso0), 32'd0);
            checkOutput("postClearI", 32'(idbuso1), 32'd0);
        end

        // Reset at clear edge 8 restarts a full clear.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd1, 16'h1111, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midClearResetBusy", 32'(busy0), 32'd1);
        checkOutput("midClearResetD", 32'(dbuso1), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        waitIdle("clearResetBusyEdges");
        readBoth(4'd1, 4'd1);
        checkOutput("finalRead", 32'(dbuso0), 32'h0000);

        @(negedge clk);
        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ram_unit_be.md
Name: ram_unit_be

Overview:
- Next-generation dual-port on-chip RAM: one data port and one instruction port, each with read and write.
- Adds per-lane byte enables, an optional registered read path and a deterministic write-collision policy.
- Adds a hardware clear sequencer that zeroes the array after reset or on request, replacing simulation-only initialisation.
- Used as data/instruction memory behind the core's load/store and fetch units.

Parameters:
- A, 8, address width; depth = 2**A words.
- D, 8, data width; must be a multiple of LANE.
- LANE, 8, byte-enable lane width; NL = D/LANE lanes.
- RD_REG, 0, 0 = combinational read; 1 = registered read, 1-cycle latency.
- PRIO, 0, lane collision winner on same-address dual write: 0 = data port, 1 = instruction port.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  request full-array zeroing (sampled in IDLE only)
- busy  out  1  clear sequencer running; port accesses blocked
- address  in  A  data-port address
- dbusi  in  D  data-port write data
- dbuso  out  D  data-port read data
- ce  in  1  data-port enable
- we  in  1  data-port write enable
- be  in  NL  data-port lane enables
- iaddress  in  A  instruction-port address
- idbusi  in  D  instruction-port write data
- idbuso  out  D  instruction-port read data
- ice  in  1  instruction-port enable
- iwe  in  1  instruction-port write enable
- ibe  in  NL  instruction-port lane enables

Behaviour:
- Reset and clock: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=CLEAR, clr_ptr=0, busy=1; RD_REG=1 output registers=0.
- Sequencer has two states, CLEAR and IDLE.
- CLEAR: each edge writes mem[clr_ptr]<=0 and clr_ptr<=clr_ptr+1. On the edge that writes address 2**A-1, go to IDLE and busy<=0.
- CLEAR timing: busy is low after exactly 2**A edges following rst_n release.
- IDLE with clear=1 at an edge: next state CLEAR, clr_ptr<=0, busy<=1. Total busy time is 2**A edges after the sampled edge.
- Port writes in the same cycle clear is sampled are dropped.
- clear during CLEAR is ignored; no restart, no extension.
- While busy: all port writes are ignored. dbuso/idbuso read 0 (RD_REG=0 forced; RD_REG=1 registers load 0).
- Write (IDLE): at an edge with ce&we, each lane k with be[k]=1 gets mem[address][k*LANE+:LANE]<=dbusi lane k. Lanes with be[k]=0 are unchanged. Same rule for the instruction port.
- Collision, same address, both ports writing: resolved per lane. A lane enabled by one port takes that port's data. A lane enabled by both takes the PRIO winner. Lanes enabled by neither are unchanged.
- Different addresses: both writes complete independently.
- Read, RD_REG=0: dbuso=mem[address] combinationally, regardless of ce; idbuso likewise.
- Read, RD_REG=1: on an edge with ce, dbuso<=mem[address]. Holds when ce=0.
- Read-first semantics: a read of an address written at the same edge (either port) returns pre-write data. New data is visible the following cycle.
- we=1 with be=0: no array change; the read still occurs.
- Reset mid-clear or mid-access: immediate return to reset values, then a full clear restarts from address 0.

Test Plan:
- A=4, D=16, LANE=8, RD_REG=1. Release rst_n -> busy=1 for exactly 16 edges, then 0. Reads of all 16 addresses return 0x0000.
- IDLE: data-port write addr 3, 0xABCD, be=11. Next edge, instruction-port read addr 3 -> idbuso=0xABCD one cycle after the read edge. Same-edge read of addr 3 -> previous value 0x0000.
- Addr 5 holds 0x1234. Write be=01, 0xFFEE -> 0x12EE. Then be=10, 0x77xx -> 0x77EE. be=00 -> unchanged.
- Same-edge dual write, addr 7. Data port 0xAAAA be=11; instruction port 0x5555 be=01. PRIO=0 -> 0xAAAA. PRIO=1 -> 0xAA55.
- IDLE, memory non-zero. Pulse clear together with a write to addr 2 -> write dropped, busy=1 for 16 edges. Mid-clear writes ignored and reads return 0. A second clear pulse mid-clear does not extend busy. Afterwards all words are 0.
- Assert rst_n low at clear edge 8 -> outputs 0 immediately. After release, busy lasts a full 16 edges.
